// File: rtl/track_player.sv
// track_player: streams a fixed-length track from a word loader, one attenuated sample per tick.
// Define TRACK_PLAYER_LOOP_EN to restart the track after the end instead of returning to idle.
module track_player #(
  parameter int WORD_WIDTH   = 16,
  parameter int RD_LATENCY   = 2,
  parameter int PRIME_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_play,
  input  logic                  i_stop,
  input  logic                  i_sample_tick,
  input  logic [31:0]           i_track_len,
  input  logic [3:0]            i_atten,
  output logic                  o_load_req,
  output logic                  o_rd,
  input  logic [WORD_WIDTH-1:0] i_dout_in,
  output logic [WORD_WIDTH-1:0] o_sample_out,
  output logic                  o_sample_valid,
  output logic                  o_playing,
  output logic                  o_done,
  output logic [7:0]            o_underrun_cnt
);
  localparam int PW = $clog2(PRIME_CYCLES + 1);
  localparam int LW = $clog2(RD_LATENCY + 2);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
`ifdef TRACK_PLAYER_LOOP_EN
  localparam logic [2:0] S_REARM = 3'd4;
`endif
  logic [2:0]                   r_state;
  logic [PW-1:0]                r_prime;
  logic [LW-1:0]                r_lat;
  logic [31:0]                  r_cnt;
  logic [31:0]                  r_len;
  logic                         r_rd;
  logic                         r_valid;
  logic                         r_done;
  logic [WORD_WIDTH-1:0]        r_out;
  logic [7:0]                   r_under;
  logic signed [WORD_WIDTH-1:0] w_sample;
  logic                         w_cap;
  logic                         w_last;
  logic                         w_busy;
  assign w_sample = $signed(i_dout_in) >>> i_atten;
  assign w_cap    = (r_state == S_FETCH) && (r_lat == LW'(RD_LATENCY));
  assign w_last   = (r_cnt + 32'd1) == r_len;
`ifdef TRACK_PLAYER_LOOP_EN
  assign w_busy = (r_state == S_FETCH) || (r_state == S_REARM);
`else
  assign w_busy = r_state == S_FETCH;
`endif
  assign o_load_req     = (r_state == S_PRIME) || (r_state == S_RUN) || (r_state == S_FETCH);
  assign o_playing      = r_state != S_IDLE;
  assign o_rd           = r_rd;
  assign o_sample_out   = r_out;
  assign o_sample_valid = r_valid;
  assign o_done         = r_done;
  assign o_underrun_cnt = r_under;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prime <= '0;
      r_lat   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_under <= '0;
    end else begin
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (i_stop) r_state <= S_IDLE;
      else case (r_state)
        S_IDLE: if (i_play) begin
          if (i_track_len == 32'd0) r_done <= 1'b1;
          else begin
            r_state <= S_PRIME;
            r_len   <= i_track_len;
            r_cnt   <= '0;
            r_under <= '0;
            r_prime <= '0;
          end
        end
        S_PRIME: begin
          r_prime <= r_prime + PW'(1);
          if (r_prime == PW'(PRIME_CYCLES - 1)) r_state <= S_RUN;
        end
        S_RUN: if (i_sample_tick) begin
          r_rd    <= 1'b1;
          r_lat   <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_lat <= r_lat + LW'(1);
          if (w_cap) begin
            r_out   <= w_sample;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + 32'd1;
            if (w_last) begin
              r_done <= 1'b1;
`ifdef TRACK_PLAYER_LOOP_EN
              r_state <= S_REARM;
              r_cnt   <= '0;
              r_prime <= '0;
`else
              r_state <= S_IDLE;
`endif
            end else r_state <= S_RUN;
          end
        end
`ifdef TRACK_PLAYER_LOOP_EN
        // load_req stays low for two cycles so the loader rewinds its address
        S_REARM: begin
          r_prime <= r_prime + PW'(1);
          if (r_prime == PW'(1)) begin
            r_state <= S_PRIME;
            r_prime <= '0;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
      if (!i_stop && w_busy && i_sample_tick && r_under != 8'hFF) r_under <= r_under + 8'd1;
    end
  end
endmodule

// File: doc/track_player.md
TRACK_PLAYER -- requirements
Module: track_player

Interface
REQ-001 Parameter WORD_WIDTH, default 16: sample width, multiple of 8.
REQ-002 Parameter RD_LATENCY, default 2: cycles from rd pulse to valid dout_in.
REQ-003 Parameter PRIME_CYCLES, default 65536: cycles that load_req is held before the first rd, so the loader can fill its first 512-byte block.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 play  in  1  single-cycle start pulse.
REQ-007 stop  in  1  single-cycle abort pulse.
REQ-008 sample_tick  in  1  single-cycle pulse at the audio sample rate.
REQ-009 track_len  in  32  track length in samples; latched on the accepted play pulse.
REQ-010 atten  in  4  attenuation as an arithmetic right-shift count; sampled at capture.
REQ-011 load_req  out  1  request level to the track loader.
REQ-012 rd  out  1  single-cycle word request to the loader.
REQ-013 dout_in  in  WORD_WIDTH  word from the loader.
REQ-014 sample_out  out  WORD_WIDTH  signed attenuated sample.
REQ-015 sample_valid  out  1  single-cycle pulse when sample_out updates.
REQ-016 playing  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse at track end.
REQ-018 underrun_cnt  out  8  count of dropped sample ticks; saturates at 255.

Function
REQ-019 The state machine SHALL have the states IDLE, PRIME, RUN, FETCH and REARM.
REQ-020 IDLE: load_req=0; play with track_len!=0 -> PRIME, clear sample counter, clear underrun_cnt.
REQ-021 Play with track_len==0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-022 PRIME: load_req=1; count PRIME_CYCLES cycles, then -> RUN; ticks arriving in PRIME SHALL be ignored and not counted.
REQ-023 RUN: load_req=1; on sample_tick, assert rd for exactly 1 cycle on the next cycle, then -> FETCH.
REQ-024 FETCH: RD_LATENCY cycles after the rd pulse, capture sample_out = $signed(dout_in) >>> atten, pulse sample_valid the following cycle, and increment the sample counter.
REQ-025 After capture, if the sample counter == latched track_len -> end-of-track handling; otherwise -> RUN.
REQ-026 A sample_tick arriving in FETCH or REARM SHALL be dropped and SHALL increment underrun_cnt (saturating).
REQ-027 rd SHALL never be high on 2 consecutive cycles and SHALL be low outside the RUN->FETCH transition, so every request is a clean rising edge.
REQ-028 Stop in any state -> IDLE on the next cycle, load_req=0; no sample_valid or done after stop; a fetch in flight is discarded.
REQ-029 Play and stop in the same cycle: stop wins.
REQ-030 Play while playing=1 SHALL be ignored.
REQ-031 The sample counter SHALL be 32 bits and compared for equality only, so no wrap occurs below track_len.
REQ-032 sample_out SHALL hold its last value between sample_valid pulses.

Reset
REQ-033 On rst: state=IDLE, load_req=0, rd=0, sample_out=0, sample_valid=0, done=0, playing=0, underrun_cnt=0, counters=0.
REQ-034 rst mid-play SHALL take effect on the next edge and take priority over play and stop.

Configuration
REQ-035 Macro TRACK_PLAYER_LOOP_EN SHALL compile looping in or out.
REQ-036 With TRACK_PLAYER_LOOP_EN defined, end of track:
- pulse done;
- -> REARM, holding load_req=0 for 2 cycles so the loader resets its address;
- -> PRIME, with the sample counter cleared;
- underrun_cnt is not cleared.
REQ-037 Without TRACK_PLAYER_LOOP_EN, end of track: pulse done -> IDLE, load_req=0; the REARM state SHALL be absent.

Verification
REQ-038 PRIME_CYCLES=8, track_len=3, loader model returns 0x1000, 0x2000, 0x3000, ticks every 50 cycles, atten=0 -> 3 rd pulses, sample_valid with those values, 1 done pulse, playing=0 (loop off).
REQ-039 dout_in=0x8000, atten=4 -> sample_out=0xF800; dout_in=0x7FF0, atten=15 -> 0x0000.
REQ-040 Second tick 1 cycle after the first tick -> underrun_cnt=1, only 1 rd pulse; 300 such ticks -> underrun_cnt=255.
REQ-041 Stop asserted on the rd cycle -> next cycle state=IDLE, load_req=0, no sample_valid within 5 cycles; play in the same cycle as stop -> stays IDLE.
REQ-042 Loop on, track_len=2 -> done after the 2nd sample, load_req low for exactly 2 cycles, PRIME again, next rd after PRIME_CYCLES.
REQ-043 Play with track_len=0 -> done pulse 1 cycle later, load_req never high; rst during RUN -> all outputs 0 on the next cycle.
